// File: rtl/rf_write_arbiter_if.sv
// Writeback request bus shared by the register-file write arbiter and its requesters.
// Requester i owns bit i of valid/ready and slice i of the address and data vectors.
interface rf_write_arbiter_if #(
  parameter int WORD_LEN = 32,
  parameter int NUM_REQ  = 2
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [4*NUM_REQ-1:0]        req_addr;
  logic [WORD_LEN*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]          req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: runs an index-loading init sweep after reset,
// then grants one writeback requester per cycle in round-robin order.
module rf_write_arbiter #(
  parameter int WORD_LEN   = 32,
  parameter int WORD_COUNT = 16,
  parameter int NUM_REQ    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  rf_write_arbiter_if.slave   reqBus,
  output logic                regWrite,
  output logic [3:0]          writeRegister,
  output logic [WORD_LEN-1:0] writeData,
  output logic [1:0]          grant_id,
  output logic                init_done
);

  localparam logic [0:0] INIT      = 1'b0;
  localparam logic [0:0] RUN       = 1'b1;
  localparam logic [3:0] LAST_ADDR = 4'(WORD_COUNT - 1);

  logic [0:0]          stateR;
  logic [3:0]          cntR;
  logic [1:0]          ptrR;

  logic                hiFoundS;
  logic                loFoundS;
  logic [1:0]          hiIdxS;
  logic [1:0]          loIdxS;
  logic [1:0]          grantIdxS;
  logic [1:0]          nextPtrS;
  logic                grantValidS;
  logic [3:0]          selAddrS;
  logic [WORD_LEN-1:0] selDataS;
  logic [NUM_REQ-1:0]  readyS;

  // Round-robin pick: lowest valid index at/after ptr, else lowest valid index overall.
  always_comb begin
    hiFoundS = 1'b0;
    loFoundS = 1'b0;
    hiIdxS   = 2'd0;
    loIdxS   = 2'd0;
    selAddrS = 4'd0;
    selDataS = '0;
    readyS   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      loFoundS = loFoundS | reqBus.req_valid[i];
      loIdxS   = reqBus.req_valid[i] ? 2'(i) : loIdxS;
      hiFoundS = hiFoundS | (reqBus.req_valid[i] && (i >= int'(ptrR)));
      hiIdxS   = (reqBus.req_valid[i] && (i >= int'(ptrR))) ? 2'(i) : hiIdxS;
    end
    grantValidS = (stateR == RUN) && !freeze && loFoundS;
    grantIdxS   = hiFoundS ? hiIdxS : loIdxS;
    nextPtrS    = (grantIdxS == 2'(NUM_REQ - 1)) ? 2'd0 : (grantIdxS + 2'd1);
    for (int i = 0; i < NUM_REQ; i++) begin
      selAddrS  = (grantIdxS == 2'(i)) ? reqBus.req_addr[4*i +: 4] : selAddrS;
      selDataS  = (grantIdxS == 2'(i)) ? reqBus.req_data[WORD_LEN*i +: WORD_LEN] : selDataS;
      readyS[i] = grantValidS && (grantIdxS == 2'(i));
    end
  end

  assign reqBus.req_ready = readyS;

  // Sequencer: sweep counter and INIT -> RUN transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateR    <= INIT;
      cntR      <= 4'd1;
      init_done <= 1'b0;
    end else begin
      case (stateR)
        INIT: begin
          cntR <= cntR + 4'd1;
          if (cntR == LAST_ADDR) begin
            stateR    <= RUN;
            init_done <= 1'b1;
          end else begin
            stateR    <= INIT;
            init_done <= 1'b0;
          end
        end
        RUN: begin
          stateR    <= RUN;
          cntR      <= cntR;
          init_done <= 1'b1;
        end
        default: begin
          stateR    <= INIT;
          cntR      <= 4'd1;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  // Registered write port, priority pointer and last-grant index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWrite      <= 1'b0;
      writeRegister <= 4'd0;
      writeData     <= '0;
      grant_id      <= 2'd0;
      ptrR          <= 2'd0;
    end else begin
      case (stateR)
        INIT: begin
          regWrite      <= 1'b1;
          writeRegister <= cntR;
          writeData     <= WORD_LEN'(cntR);
        end
        RUN: begin
          if (grantValidS) begin
            // A grant to register 0 is consumed but never strobed into the file.
            regWrite      <= (selAddrS != 4'd0);
            writeRegister <= selAddrS;
            writeData     <= selDataS;
            grant_id      <= grantIdxS;
            ptrR          <= nextPtrS;
          end else begin
            regWrite      <= 1'b0;
          end
        end
        default: begin
          regWrite <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a NUM_REQ=2 instance driven from a vector table
// plus reset/sweep sequences, and a NUM_REQ=3 instance for pointer wrap-around.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        frz2;
  logic        frz3;
  logic        rw2, rw3;
  logic [3:0]  wa2, wa3;
  logic [31:0] wd2, wd3;
  logic [1:0]  gid2, gid3;
  logic        id2, id3;

  int checkCnt;
  int passCnt;

  rf_write_arbiter_if #(.WORD_LEN(32), .NUM_REQ(2)) bus2 ();
  rf_write_arbiter_if #(.WORD_LEN(32), .NUM_REQ(3)) bus3 ();

  rf_write_arbiter #(.WORD_LEN(32), .WORD_COUNT(16), .NUM_REQ(2)) dut2 (
    .clk(clk), .rst(rst), .freeze(frz2), .reqBus(bus2),
    .regWrite(rw2), .writeRegister(wa2), .writeData(wd2),
    .grant_id(gid2), .init_done(id2)
  );

  rf_write_arbiter #(.WORD_LEN(32), .WORD_COUNT(16), .NUM_REQ(3)) dut3 (
    .clk(clk), .rst(rst), .freeze(frz3), .reqBus(bus3),
    .regWrite(rw3), .writeRegister(wa3), .writeData(wd3),
    .grant_id(gid3), .init_done(id3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic        frz;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  ready;
    logic        rw;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [1:0]  gid;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_rw2"},    64'(rw2),            64'd0);
    check({tag, "_wa2"},    64'(wa2),            64'd0);
    check({tag, "_wd2"},    64'(wd2),            64'd0);
    check({tag, "_gid2"},   64'(gid2),           64'd0);
    check({tag, "_init2"},  64'(id2),            64'd0);
    check({tag, "_ready2"}, 64'(bus2.req_ready), 64'd0);
    check({tag, "_gid3"},   64'(gid3),           64'd0);
  endtask

  // Runs edges 1..stopAfter of the sweep with requests and freeze asserted to prove both are ignored.
  task automatic runSweep(input int stopAfter);
    for (int e = 1; e <= stopAfter; e++) begin
      bus2.req_valid = 2'b11;
      bus2.req_addr  = {4'd5, 4'd3};
      bus2.req_data  = {32'h5555, 32'hAAAA};
      frz2 = ((e % 2) == 1);
      #1;
      check("init_ready", 64'(bus2.req_ready), 64'd0);
      @(posedge clk);
      #1;
      check("init_rw",    64'(rw2), 64'd1);
      check("init_wa",    64'(wa2), 64'(e));
      check("init_wd",    64'(wd2), 64'(e));
      check("init_done",  64'(id2), (e == 15) ? 64'd1 : 64'd0);
      check("init_wa3",   64'(wa3), 64'(e));
    end
    bus2.req_valid = 2'b00;
    frz2 = 1'b0;
  endtask

  initial begin
    int exp3[8];
    checkCnt = 0;
    passCnt  = 0;
    rst  = 1'b0;
    frz2 = 1'b0;
    frz3 = 1'b0;
    bus2.req_valid = 2'b00;
    bus2.req_addr  = '0;
    bus2.req_data  = '0;
    bus3.req_valid = 3'b000;
    bus3.req_addr  = {4'd3, 4'd2, 4'd1};
    bus3.req_data  = {32'h102, 32'h101, 32'h100};

    //             valid frz  a0    a1    d0          d1          ready rw   wa    wd          gid
    vecs[0]  = '{2'b11, 1'b0, 4'd3, 4'd5, 32'hAAAA, 32'h5555, 2'b01, 1'b1, 4'd3, 32'hAAAA, 2'd0};
    vecs[1]  = '{2'b11, 1'b0, 4'd3, 4'd5, 32'hAAAA, 32'h5555, 2'b10, 1'b1, 4'd5, 32'h5555, 2'd1};
    vecs[2]  = '{2'b11, 1'b0, 4'd3, 4'd5, 32'hAAAA, 32'h5555, 2'b01, 1'b1, 4'd3, 32'hAAAA, 2'd0};
    vecs[3]  = '{2'b11, 1'b0, 4'd3, 4'd5, 32'hAAAA, 32'h5555, 2'b10, 1'b1, 4'd5, 32'h5555, 2'd1};
    vecs[4]  = '{2'b11, 1'b1, 4'd3, 4'd5, 32'hAAAA, 32'h5555, 2'b00, 1'b0, 4'd5, 32'h5555, 2'd1};
    vecs[5]  = '{2'b11, 1'b1, 4'd3, 4'd5, 32'hAAAA, 32'h5555, 2'b00, 1'b0, 4'd5, 32'h5555, 2'd1};
    vecs[6]  = '{2'b11, 1'b1, 4'd3, 4'd5, 32'hAAAA, 32'h5555, 2'b00, 1'b0, 4'd5, 32'h5555, 2'd1};
    vecs[7]  = '{2'b11, 1'b0, 4'd3, 4'd5, 32'hAAAA, 32'h5555, 2'b01, 1'b1, 4'd3, 32'hAAAA, 2'd0};
    vecs[8]  = '{2'b10, 1'b0, 4'd3, 4'd0, 32'hAAAA, 32'h1234, 2'b10, 1'b0, 4'd0, 32'h1234, 2'd1};
    vecs[9]  = '{2'b10, 1'b0, 4'd3, 4'd7, 32'hAAAA, 32'h0077, 2'b10, 1'b1, 4'd7, 32'h0077, 2'd1};
    vecs[10] = '{2'b00, 1'b0, 4'd3, 4'd7, 32'hAAAA, 32'h0077, 2'b00, 1'b0, 4'd7, 32'h0077, 2'd1};
    vecs[11] = '{2'b01, 1'b0, 4'd9, 4'd7, 32'h0099, 32'h0077, 2'b01, 1'b1, 4'd9, 32'h0099, 2'd0};
    vecs[12] = '{2'b01, 1'b0, 4'd9, 4'd7, 32'h009A, 32'h0077, 2'b01, 1'b1, 4'd9, 32'h009A, 2'd0};
    vecs[13] = '{2'b11, 1'b0, 4'd2, 4'd4, 32'h0022, 32'h0044, 2'b10, 1'b1, 4'd4, 32'h0044, 2'd1};
    vecs[14] = '{2'b11, 1'b0, 4'd2, 4'd4, 32'h0022, 32'h0044, 2'b01, 1'b1, 4'd2, 32'h0022, 2'd0};
    vecs[15] = '{2'b00, 1'b1, 4'd2, 4'd4, 32'h0022, 32'h0044, 2'b00, 1'b0, 4'd2, 32'h0022, 2'd0};

    exp3 = '{0, 1, 2, 0, 2, 0, 2, 0};

    // Power-on reset values.
    #2;
    checkResetOutputs("por");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Partial sweep, then asynchronous reset after edge 6.
    runSweep(6);
    #2;
    rst = 1'b0;
    #1;
    checkResetOutputs("sweep_rst");
    #1;
    rst = 1'b1;

    // Full sweep from R1, then an idle edge 16.
    runSweep(15);
    #1;
    check("e16_ready", 64'(bus2.req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("e16_rw", 64'(rw2), 64'd0);
    check("e16_wa", 64'(wa2), 64'd15);
    check("e16_wd", 64'(wd2), 64'd15);

    // Table-driven RUN vectors for the 2-requester instance.
    for (int k = 0; k < 16; k++) begin
      bus2.req_valid = vecs[k].valid;
      bus2.req_addr  = {vecs[k].a1, vecs[k].a0};
      bus2.req_data  = {vecs[k].d1, vecs[k].d0};
      frz2           = vecs[k].frz;
      #1;
      check($sformatf("v%0d_ready", k), 64'(bus2.req_ready), 64'(vecs[k].ready));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rw", k),  64'(rw2),  64'(vecs[k].rw));
      check($sformatf("v%0d_wa", k),  64'(wa2),  64'(vecs[k].wa));
      check($sformatf("v%0d_wd", k),  64'(wd2),  64'(vecs[k].wd));
      check($sformatf("v%0d_gid", k), 64'(gid2), 64'(vecs[k].gid));
    end

    // Reset while a grant is pending (ptr=1 so req1 is offered).
    frz2 = 1'b0;
    bus2.req_valid = 2'b11;
    bus2.req_addr  = {4'd5, 4'd3};
    bus2.req_data  = {32'h5555, 32'hAAAA};
    #1;
    check("pend_ready", 64'(bus2.req_ready), 64'd2);
    rst = 1'b0;
    #1;
    checkResetOutputs("run_rst");
    #1;
    rst = 1'b1;
    runSweep(15);

    // Pointer restarts at 0 after reset.
    bus2.req_valid = 2'b11;
    #1;
    check("post_rst_ready", 64'(bus2.req_ready), 64'd1);
    @(posedge clk);
    #1;
    check("post_rst_gid", 64'(gid2), 64'd0);
    check("post_rst_wa",  64'(wa2),  64'd3);
    bus2.req_valid = 2'b00;

    // 3-requester wrap: all valid gives 0,1,2,0; dropping req1 gives 2,0,2,0.
    for (int k = 0; k < 8; k++) begin
      bus3.req_valid = (k < 4) ? 3'b111 : 3'b101;
      #1;
      check($sformatf("n3_%0d_ready", k), 64'(bus3.req_ready), 64'd1 << exp3[k]);
      @(posedge clk);
      #1;
      check($sformatf("n3_%0d_gid", k), 64'(gid3), 64'(exp3[k]));
      check($sformatf("n3_%0d_wa", k),  64'(wa3),  64'(exp3[k] + 1));
      check($sformatf("n3_%0d_wd", k),  64'(wd3),  64'(32'h100 + exp3[k]));
      check($sformatf("n3_%0d_rw", k),  64'(rw3),  64'd1);
    end
    bus3.req_valid = 3'b000;

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
